snd_queue: RTL and testbench

Sound request queue sitting directly upstream of `sndm`. It accepts one-cycle sound event pulses from the game FSM, buffers them in a small FIFO, and issues them to `sndm` one at a time on `snd_mode`/`trig`. It holds `snd_mode` stable for the whole note sequence and waits for `playing` to fall before issuing the next sound. Game-over and game-clear events pre-empt everything.

---
 rtl/snd_pkg.sv | 37 +++
 rtl/snd_fifo.sv | 61 ++++++
 rtl/snd_queue.sv | 143 ++++++++++++++
 tb/tb_snd_queue.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snd_pkg.sv
// Shared sound definitions for the sound request queue and the sndm player.
// Holds the sound codes, the queue FSM states and the priority classifier.
package snd_pkg;

    localparam int unsigned SND_CODE_W = 3;

    localparam logic [SND_CODE_W-1:0] SND_NONE      = 3'b000;
    localparam logic [SND_CODE_W-1:0] SND_BEEP      = 3'b001;
    localparam logic [SND_CODE_W-1:0] SND_START     = 3'b010;
    localparam logic [SND_CODE_W-1:0] SND_HIT       = 3'b011;
    localparam logic [SND_CODE_W-1:0] SND_MISS      = 3'b100;
    localparam logic [SND_CODE_W-1:0] SND_WIN       = 3'b101;
    localparam logic [SND_CODE_W-1:0] SND_GAMEOVER  = 3'b110;
    localparam logic [SND_CODE_W-1:0] SND_GAMECLEAR = 3'b111;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REARM      = 3'd1,
        ISSUE      = 3'd2,
        WAIT_START = 3'd3,
        WAIT_END   = 3'd4,
        GAP        = 3'd5
    } snd_state_e;

    // Game-over and game-clear bypass the queue and pre-empt any sound in flight.
    function automatic logic is_priority(input logic [SND_CODE_W-1:0] code);
        return (code == SND_GAMEOVER) || (code == SND_GAMECLEAR);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/snd_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
// Flush beats push; a push into a full FIFO is taken only when a pop happens too.
module snd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 3
) (
    input  logic                         clk_1mhz,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);
    assign pop_data  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push_c) - CW'(do_pop_c);
        end
    end

    always_ff @(posedge clk_1mhz) begin
        if (do_push_c && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/snd_queue.sv
// Sound request queue in front of sndm: buffers sound events, issues them one at
// a time with a trig pulse, and lets game-over/game-clear pre-empt everything.
module snd_queue #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned TRIG_CYCLES   = 4,
    parameter int unsigned START_TIMEOUT = 16,
    parameter int unsigned GAP_CYCLES    = 20000
) (
    input  logic                         clk_1mhz,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic [2:0]                   req_code,
    input  logic                         playing,
    output logic [2:0]                   snd_mode,
    output logic                         trig,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   q_count,
    output logic                         drop
);

    import snd_pkg::*;

    localparam int unsigned QW      = $clog2(DEPTH + 1);
    localparam int unsigned CNT_MAX = max3(TRIG_CYCLES, START_TIMEOUT, GAP_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    snd_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         pend;

    logic               prio_req_c;
    logic               normal_req_c;
    logic               pop_c;
    logic [2:0]         fifo_data;
    logic [QW-1:0]      fifo_count;
    logic               fifo_empty;
    logic               fifo_full;

    assign prio_req_c   = req_valid && is_priority(req_code);
    assign normal_req_c = req_valid && (req_code != SND_NONE) && !is_priority(req_code);
    assign pop_c        = (state == IDLE) && !fifo_empty && !prio_req_c;

    assign q_count = fifo_count;
    assign busy    = (state != IDLE) || !fifo_empty;

    snd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SND_CODE_W)
    ) u_fifo (
        .clk_1mhz  (clk_1mhz),
        .rst       (rst),
        .push      (normal_req_c),
        .push_data (req_code),
        .pop       (pop_c),
        .flush     (prio_req_c),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Issue FSM; the shared counter is cleared on every state entry.
    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pend     <= SND_NONE;
            snd_mode <= SND_NONE;
            trig     <= 1'b0;
            drop     <= 1'b0;
        end else begin
            drop <= normal_req_c && fifo_full && !pop_c;
            cnt  <= cnt + CNT_W'(1);

            if (prio_req_c) begin
                pend  <= req_code;
                state <= REARM;
                cnt   <= '0;
                trig  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        trig <= 1'b0;
                        if (!fifo_empty) begin
                            snd_mode <= fifo_data;
                            trig     <= 1'b1;
                            state    <= ISSUE;
                            cnt      <= '0;
                        end
                    end
                    // Two low cycles give sndm's synchronizer a fresh rising edge.
                    REARM: begin
                        trig <= 1'b0;
                        if (cnt == CNT_W'(1)) begin
                            snd_mode <= pend;
                            trig     <= 1'b1;
                            state    <= ISSUE;
                            cnt      <= '0;
                        end
                    end
                    ISSUE: begin
                        if (cnt == CNT_W'(TRIG_CYCLES - 1)) begin
                            trig  <= 1'b0;
                            state <= playing ? WAIT_END : WAIT_START;
                            cnt   <= '0;
                        end
                    end
                    WAIT_START: begin
                        trig <= 1'b0;
                        if (playing) begin
                            state <= WAIT_END;
                            cnt   <= '0;
                        end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                            state <= GAP;
                            cnt   <= '0;
                        end
                    end
                    WAIT_END: begin
                        trig <= 1'b0;
                        if (!playing) begin
                            state <= GAP;
                            cnt   <= '0;
                        end
                    end
                    // The WAIT_END cycle that saw playing fall is the first silent cycle.
                    GAP: begin
                        trig <= 1'b0;
                        if (cnt == CNT_W'(GAP_CYCLES - 2)) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        trig  <= 1'b0;
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snd_queue.sv
// Directed bench for snd_queue with a small sndm model that raises playing two
// cycles after trig rises and holds it for PLAY_LEN cycles.
module tb_snd_queue;

    import snd_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned TRIG     = 4;
    localparam int unsigned TMO      = 16;
    localparam int unsigned GAPC     = 20;
    localparam int unsigned PLAY_LEN = 30;
    localparam int unsigned QW       = $clog2(DEPTH + 1);

    logic           clk_1mhz  = 1'b0;
    logic           rst       = 1'b1;
    logic           req_valid = 1'b0;
    logic [2:0]     req_code  = 3'b000;
    logic           playing   = 1'b0;
    logic [2:0]     snd_mode;
    logic           trig;
    logic           busy;
    logic [QW-1:0]  q_count;
    logic           drop;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    snd_queue #(
        .DEPTH         (DEPTH),
        .TRIG_CYCLES   (TRIG),
        .START_TIMEOUT (TMO),
        .GAP_CYCLES    (GAPC)
    ) dut (
        .clk_1mhz  (clk_1mhz),
        .rst       (rst),
        .req_valid (req_valid),
        .req_code  (req_code),
        .playing   (playing),
        .snd_mode  (snd_mode),
        .trig      (trig),
        .busy      (busy),
        .q_count   (q_count),
        .drop      (drop)
    );

    always #5 clk_1mhz = ~clk_1mhz;

    always @(posedge clk_1mhz) cyc <= cyc + 1;

    // sndm model
    logic model_en  = 1'b1;
    logic trig_prev = 1'b0;
    logic rise_d    = 1'b0;
    int   play_left = 0;

    always @(posedge clk_1mhz) begin
        trig_prev <= trig;
        rise_d    <= trig && !trig_prev && model_en;
        if (rst) begin
            playing <= 1'b0;
            rise_d  <= 1'b0;
        end else if (rise_d) begin
            playing   <= 1'b1;
            play_left <= PLAY_LEN - 1;
        end else if (playing) begin
            if (play_left == 0) playing <= 1'b0;
            else play_left <= play_left - 1;
        end
    end

    // Record every issued sound (code and cycle of the trig rising edge).
    logic       trig_last = 1'b0;
    logic [2:0] iss_code[$];
    int         iss_cyc[$];

    always @(negedge clk_1mhz) begin
        if (trig && !trig_last) begin
            iss_code.push_back(snd_mode);
            iss_cyc.push_back(cyc);
        end
        trig_last = trig;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_1mhz);
        #1;
    endtask

    task automatic req(input logic [2:0] c);
        req_valid = 1'b1;
        req_code  = c;
        step(1);
        req_valid = 1'b0;
        req_code  = 3'b000;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    task automatic clear_log();
        iss_code.delete();
        iss_cyc.delete();
    endtask

    logic [2:0] burst [6] = '{3'b001, 3'b011, 3'b100, 3'b101, 3'b011, 3'b001};
    int qc [6];
    int dr [6];
    int tg [6];

    initial begin
        // Reset state
        rst = 1'b1;
        step(3);
        chk("rst_mode", 32'(snd_mode), 0);
        chk("rst_trig", 32'(trig), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_qcnt", 32'(q_count), 0);
        chk("rst_drop", 32'(drop), 0);
        rst = 1'b0;
        step(2);

        // Code 000 is ignored
        req(3'b000);
        chk("zero_qcnt", 32'(q_count), 0);
        chk("zero_busy", 32'(busy), 0);
        step(2);

        // Single hit: request at k
        clear_log();
        req(SND_HIT);                              // k+1
        chk("hit_qcnt1", 32'(q_count), 1);
        chk("hit_trig_k1", 32'(trig), 0);
        step(1);                                   // k+2
        chk("hit_trig_k2", 32'(trig), 1);
        chk("hit_mode", 32'(snd_mode), 32'(SND_HIT));
        chk("hit_qcnt2", 32'(q_count), 0);
        step(3);                                   // k+5
        chk("hit_trig_k5", 32'(trig), 1);
        step(1);                                   // k+6
        chk("hit_trig_k6", 32'(trig), 0);
        step(47);                                  // k+53, last GAP cycle
        chk("hit_busy_gap", 32'(busy), 1);
        step(1);                                   // k+54, IDLE
        chk("hit_busy_idle", 32'(busy), 0);
        chk("hit_mode_held", 32'(snd_mode), 32'(SND_HIT));
        chk("hit_n_issued", 32'(iss_code.size()), 1);
        step(3);

        // Burst on consecutive cycles
        clear_log();
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_code  = burst[i];
            step(1);
            qc[i] = int'(q_count);
            dr[i] = int'(drop);
            tg[i] = int'(trig);
        end
        req_valid = 1'b0;
        req_code  = 3'b000;
        chk("burst_qc0", 32'(qc[0]), 1);
        chk("burst_qc1", 32'(qc[1]), 1);
        chk("burst_qc4", 32'(qc[4]), 4);
        chk("burst_qc5", 32'(qc[5]), 4);
        chk("burst_trig", 32'(tg[1]), 1);
        chk("burst_drop_pre", 32'(dr[4]), 0);
        chk("burst_drop", 32'(dr[5]), 1);
        step(1);
        chk("burst_drop_post", 32'(drop), 0);
        wait_idle("burst_idle", 1000);
        chk("burst_n_issued", 32'(iss_code.size()), 5);
        if (iss_code.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("burst_order%0d", i), 32'(iss_code[i]), 32'(burst[i]));
            end
            chk("burst_spacing", 32'(iss_cyc[1] - iss_cyc[0]), 53);
        end
        step(3);

        // Pre-emption during WAIT_END with two queued
        clear_log();
        req(SND_HIT);                              // p+1
        req(SND_BEEP);                             // p+2
        req(SND_MISS);                             // p+3
        chk("pre_qcnt", 32'(q_count), 2);
        step(6);                                   // p+9
        req(SND_GAMEOVER);                         // p+10
        chk("pre_qcnt0", 32'(q_count), 0);
        chk("pre_trig_r1", 32'(trig), 0);
        step(1);                                   // p+11
        chk("pre_trig_r2", 32'(trig), 0);
        step(1);                                   // p+12
        chk("pre_trig", 32'(trig), 1);
        chk("pre_mode", 32'(snd_mode), 32'(SND_GAMEOVER));
        wait_idle("pre_idle", 1000);
        chk("pre_n_issued", 32'(iss_code.size()), 2);
        if (iss_code.size() == 2) begin
            chk("pre_first", 32'(iss_code[0]), 32'(SND_HIT));
            chk("pre_second", 32'(iss_code[1]), 32'(SND_GAMEOVER));
        end
        step(3);

        // Stuck sndm: playing never rises
        clear_log();
        model_en = 1'b0;
        req(SND_BEEP);                             // s+1
        step(1);                                   // s+2
        chk("stuck_trig", 32'(trig), 1);
        step(4);                                   // s+6
        chk("stuck_trig_off", 32'(trig), 0);
        chk("stuck_busy_ws", 32'(busy), 1);
        step(34);                                  // s+40, last GAP cycle
        chk("stuck_busy_gap", 32'(busy), 1);
        step(1);                                   // s+41
        chk("stuck_busy_idle", 32'(busy), 0);
        model_en = 1'b1;
        step(3);

        // Full FIFO with a request in the cycle IDLE pops
        clear_log();
        req(SND_BEEP);                             // f+1
        req(SND_HIT);                              // f+2
        req(SND_MISS);                             // f+3
        req(SND_WIN);                              // f+4
        req(SND_BEEP);                             // f+5
        chk("fwp_full", 32'(q_count), 4);
        step(49);                                  // f+54, IDLE pops
        chk("fwp_qcnt_pre", 32'(q_count), 4);
        chk("fwp_trig_pre", 32'(trig), 0);
        req(SND_START);                            // f+55
        chk("fwp_qcnt", 32'(q_count), 4);
        chk("fwp_drop", 32'(drop), 0);
        chk("fwp_trig", 32'(trig), 1);
        chk("fwp_mode", 32'(snd_mode), 32'(SND_HIT));
        step(1);
        chk("fwp_drop2", 32'(drop), 0);
        wait_idle("fwp_idle", 1500);
        chk("fwp_n_issued", 32'(iss_code.size()), 6);
        if (iss_code.size() == 6) begin
            chk("fwp_last", 32'(iss_code[5]), 32'(SND_START));
        end
        step(3);

        // Reset mid-WAIT_END with three queued
        req(SND_HIT);                              // r+1
        req(SND_BEEP);                             // r+2
        req(SND_MISS);                             // r+3
        req(SND_WIN);                              // r+4
        chk("rmid_qcnt", 32'(q_count), 3);
        step(6);                                   // r+10
        chk("rmid_busy", 32'(busy), 1);
        rst = 1'b1;
        step(1);                                   // r+11
        chk("rmid_trig", 32'(trig), 0);
        chk("rmid_mode", 32'(snd_mode), 0);
        chk("rmid_qcnt0", 32'(q_count), 0);
        chk("rmid_busy0", 32'(busy), 0);
        chk("rmid_drop", 32'(drop), 0);
        rst = 1'b0;
        step(5);
        chk("rmid_busy_after", 32'(busy), 0);
        chk("rmid_trig_after", 32'(trig), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
